// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding, ALU, destination
// mux, and an iterative shift-add MULTU unit with HI/LO and a pipeline stall request.
module ex_stage #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] RegRs_data,
    input  logic [31:0] RegRt_data,
    input  logic [31:0] SignExtImm,
    input  logic [4:0]  Rs,
    input  logic [4:0]  Rt,
    input  logic [4:0]  Rd,
    input  logic [4:0]  Shamt,
    input  logic [3:0]  AluCtrl,
    input  logic        AluSrc,
    input  logic        RegDst,
    input  logic        wb_RegWrite,
    input  logic        wb_MemToReg,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic        exmem_RegWrite,
    input  logic [4:0]  exmem_RegRd,
    input  logic [31:0] exmem_AluResult,
    input  logic        memwb_RegWrite,
    input  logic [4:0]  memwb_RegRd,
    input  logic [31:0] memwb_WriteData,
    output logic [31:0] AluResult,
    output logic [31:0] MuxForwardB,
    output logic [4:0]  MuxRegDst,
    output logic        wb_RegWrite_out,
    output logic        wb_MemToReg_out,
    output logic        mem_MemRead_out,
    output logic        mem_MemWrite_out,
    output logic        Stall,
    output logic        MulBusy
);

    localparam int         CYCLES     = 32 / BITS_PER_CYCLE;
    localparam logic [4:0] LAST_COUNT = 5'(CYCLES - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLL   = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_MFHI  = 4'b1001;
    localparam logic [3:0] OP_MFLO  = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic {IDLE, BUSY} mul_state_t;

    mul_state_t  state_reg;
    logic [4:0]  count_reg;
    logic [63:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic [63:0] acc_reg;
    logic [63:0] acc_next;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    logic [31:0] fwd_a;
    logic [31:0] alu_b;
    logic        mul_busy;
    logic        hilo_op;

    // EX/MEM is the younger producer, so it wins over MEM/WB.
    always_comb begin
        fwd_a = RegRs_data;
        if (exmem_RegWrite && (exmem_RegRd != 5'd0) && (exmem_RegRd == Rs))
            fwd_a = exmem_AluResult;
        else if (memwb_RegWrite && (memwb_RegRd != 5'd0) && (memwb_RegRd == Rs))
            fwd_a = memwb_WriteData;
    end

    always_comb begin
        MuxForwardB = RegRt_data;
        if (exmem_RegWrite && (exmem_RegRd != 5'd0) && (exmem_RegRd == Rt))
            MuxForwardB = exmem_AluResult;
        else if (memwb_RegWrite && (memwb_RegRd != 5'd0) && (memwb_RegRd == Rt))
            MuxForwardB = memwb_WriteData;
    end

    assign alu_b     = AluSrc ? SignExtImm : MuxForwardB;
    assign MuxRegDst = RegDst ? Rd : Rt;

    always_comb begin
        AluResult = 32'd0;
        case (AluCtrl)
            OP_AND:  AluResult = fwd_a & alu_b;
            OP_OR:   AluResult = fwd_a | alu_b;
            OP_ADD:  AluResult = fwd_a + alu_b;
            OP_SUB:  AluResult = fwd_a - alu_b;
            OP_SLT:  AluResult = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            OP_SLTU: AluResult = {31'd0, fwd_a < alu_b};
            OP_NOR:  AluResult = ~(fwd_a | alu_b);
            OP_SLL:  AluResult = alu_b << Shamt;
            OP_SRL:  AluResult = alu_b >> Shamt;
            OP_SRA:  AluResult = $unsigned($signed(alu_b) >>> Shamt);
            OP_MFHI: AluResult = hi_reg;
            OP_MFLO: AluResult = lo_reg;
            default: AluResult = 32'd0;
        endcase
    end

    // Reset overrides a running multiply immediately, so the stall drops with it.
    assign mul_busy = (state_reg == BUSY) && !reset;
    assign hilo_op  = (AluCtrl == OP_MULTU) || (AluCtrl == OP_MFHI) || (AluCtrl == OP_MFLO);
    assign Stall    = mul_busy && hilo_op;
    assign MulBusy  = mul_busy;

    assign wb_RegWrite_out  = wb_RegWrite  && !Stall;
    assign wb_MemToReg_out  = wb_MemToReg  && !Stall;
    assign mem_MemRead_out  = mem_MemRead  && !Stall;
    assign mem_MemWrite_out = mem_MemWrite && !Stall;

    logic [63:0] pp [BITS_PER_CYCLE];

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 64'd0;
        end
    endgenerate

    always_comb begin
        acc_next = acc_reg;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            acc_next = acc_next + pp[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= 5'd0;
            mcand_reg  <= 64'd0;
            mplier_reg <= 32'd0;
            acc_reg    <= 64'd0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (AluCtrl == OP_MULTU) begin
                        mcand_reg  <= {32'd0, fwd_a};
                        mplier_reg <= MuxForwardB;
                        acc_reg    <= 64'd0;
                        count_reg  <= 5'd0;
                        state_reg  <= BUSY;
                    end
                end
                BUSY: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << BITS_PER_CYCLE;
                    mplier_reg <= mplier_reg >> BITS_PER_CYCLE;
                    count_reg  <= count_reg + 5'd1;
                    if (count_reg == LAST_COUNT) begin
                        hi_reg    <= acc_next[63:32];
                        lo_reg    <= acc_next[31:0];
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
